// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak rate-block padder.
// KECCAK_SHA3_PAD_EN selects the SHA-3 domain pad byte (0x06) instead of Keccak's 0x01.
package keccak_pkg;

    localparam int BLK_W = 1152;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        MODE_1152 = 2'd0,
        MODE_1088 = 2'd1,
        MODE_832  = 2'd2,
        MODE_576  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_FULL,
        ST_DONE
    } state_e;

    localparam int RATE_1152 = 1152;
    localparam int RATE_1088 = 1088;
    localparam int RATE_832  = 832;
    localparam int RATE_576  = 576;

    localparam logic [7:0] PAD_END = 8'h80;
`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

    function automatic int rate_bits(input mode_e m);
        case (m)
            MODE_1152: return RATE_1152;
            MODE_1088: return RATE_1088;
            MODE_832:  return RATE_832;
            default:   return RATE_576;
        endcase
    endfunction

    // Words per block for a given rate and input word size.
    function automatic logic [CNT_W-1:0] wpb(input mode_e m, input int in_bytes);
        return CNT_W'(rate_bits(m) / (8 * in_bytes));
    endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational last-word former: keeps the valid leading bytes, inserts the
// pad byte right after them and zeroes the rest. Non-last words pass through.
module keccak_pad_word
    import keccak_pkg::*;
#(
    parameter int IN_BYTES = 4
) (
    input  logic [8*IN_BYTES-1:0]       in,
    input  logic [$clog2(IN_BYTES)-1:0] byte_num,
    input  logic                        is_last,
    output logic [8*IN_BYTES-1:0]       word
);

    localparam int BW = $clog2(IN_BYTES);

    // Byte 0 is the most significant byte of the word.
    for (genvar b = 0; b < IN_BYTES; b++) begin : g_byte
        localparam int HI = 8 * (IN_BYTES - b) - 1;
        assign word[HI -: 8] = (!is_last || (BW'(b) < byte_num)) ? in[HI -: 8] :
                               (BW'(b) == byte_num)               ? PAD_BYTE   : 8'h00;
    end

endmodule

// File: rtl/keccak_padder_p.sv
// Keccak padder: packs input words into a left-aligned rate block, pads the
// final block and hands it over with out_ready/ack. Pad byte set by KECCAK_SHA3_PAD_EN.
module keccak_padder_p
    import keccak_pkg::*;
#(
    parameter int IN_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [8*IN_BYTES-1:0]       in,
    input  logic                        in_ready,
    input  logic                        is_last,
    input  logic [$clog2(IN_BYTES)-1:0] byte_num,
    input  logic [1:0]                  mode,
    input  logic                        ack,
    output logic                        buffer_full,
    output logic [BLK_W-1:0]            out,
    output logic                        out_ready,
    output logic                        out_last
);

    localparam int W = 8 * IN_BYTES;
    localparam logic [BLK_W-1:0] TOP_MASK = {{W{1'b1}}, {(BLK_W-W){1'b0}}};

    state_e           state, state_nx;
    mode_e            mode_q, mode_eff;
    logic             mid;
    logic [CNT_W-1:0] cnt, last_idx;
    logic [W-1:0]     pad_word, wr_word;
    logic [BLK_W-1:0] wr_mask, wr_data;
    logic             take, wr_en, at_end, closing;

    keccak_pad_word #(.IN_BYTES(IN_BYTES)) u_pad (
        .in       (in),
        .byte_num (byte_num),
        .is_last  (is_last),
        .word     (pad_word)
    );

    // The first word of a message uses the live mode; everything after uses the latched copy.
    assign mode_eff = mid ? mode_q : mode_e'(mode);
    assign last_idx = wpb(mode_eff, IN_BYTES) - CNT_W'(1);
    assign at_end   = (cnt == last_idx);
    assign take     = (state == ST_FILL) && in_ready;
    assign wr_en    = take || (state == ST_PAD);
    assign closing  = at_end && ((take && is_last) || (state == ST_PAD));

    always_comb begin
        wr_word = (state == ST_PAD) ? '0 : pad_word;
        if (closing) wr_word[7:0] = wr_word[7:0] | PAD_END;
    end

    assign wr_mask = TOP_MASK >> (int'(cnt) * W);
    assign wr_data = {wr_word, {(BLK_W-W){1'b0}}} >> (int'(cnt) * W);

    always_comb begin
        state_nx = state;
        case (state)
            ST_FILL: begin
                if (take) begin
                    if (at_end)       state_nx = is_last ? ST_DONE : ST_FULL;
                    else if (is_last) state_nx = ST_PAD;
                end
            end
            ST_PAD:           if (at_end) state_nx = ST_DONE;
            ST_FULL, ST_DONE: if (ack)    state_nx = ST_FILL;
            default:          state_nx = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FILL;
            buffer_full <= 1'b0;
            out_ready   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            state       <= state_nx;
            buffer_full <= (state_nx != ST_FILL);
            out_ready   <= (state_nx == ST_FULL) || (state_nx == ST_DONE);
            out_last    <= (state_nx == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            cnt    <= '0;
            mode_q <= MODE_1152;
            mid    <= 1'b0;
        end else begin
            if (take && !mid) begin
                mode_q <= mode_e'(mode);
                mid    <= 1'b1;
            end
            if (wr_en) begin
                out <= (out & ~wr_mask) | wr_data;
                cnt <= cnt + CNT_W'(1);
            end
            // Handover clears the block; only a finished message releases the mode latch.
            if (ack && ((state == ST_FULL) || (state == ST_DONE))) begin
                out <= '0;
                cnt <= '0;
                if (state == ST_DONE) mid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keccak_padder_p.sv
// Scoreboard bench for keccak_padder_p: a byte-level padding model pushes
// expected blocks per message; each delivered block is popped and compared.
module tb_keccak_padder_p;

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] PB = 8'h06;
`else
    localparam logic [7:0] PB = 8'h01;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [1151:0] blk;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   in4;
    logic          in_ready, is_last, ack;
    logic [1:0]    byte_num, mode;
    logic          buffer_full, out_ready, out_last;
    logic [1151:0] out;

    logic [63:0]   in8;
    logic          in_ready8, is_last8, ack8;
    logic [2:0]    byte_num8;
    logic [1:0]    mode8;
    logic          buffer_full8, out_ready8, out_last8;
    logic [1151:0] out8;

    exp_t          sb[$];
    logic [1151:0] last_blk;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    keccak_padder_p #(.IN_BYTES(4)) dut (
        .clk(clk), .reset(reset), .in(in4), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .mode(mode), .ack(ack), .buffer_full(buffer_full),
        .out(out), .out_ready(out_ready), .out_last(out_last)
    );

    keccak_padder_p #(.IN_BYTES(8)) dut8 (
        .clk(clk), .reset(reset), .in(in8), .in_ready(in_ready8), .is_last(is_last8),
        .byte_num(byte_num8), .mode(mode8), .ack(ack8), .buffer_full(buffer_full8),
        .out(out8), .out_ready(out_ready8), .out_last(out_last8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rbytes(input logic [1:0] m);
        case (m)
            2'd0:    return 144;
            2'd1:    return 136;
            2'd2:    return 104;
            default: return 72;
        endcase
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference padding at byte level: msg || P || 0* with 0x80 ORed into the last rate byte.
    task automatic model_push(input bq_t msg, input int rb);
        bq_t  p;
        exp_t e;
        int   nb;
        p = msg;
        p.push_back(PB);
        while (p.size() % rb != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nb = p.size() / rb;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int i = 0; i < rb; i++) e.blk[1151-8*i -: 8] = p[b*rb+i];
            e.last = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge with out_ready high; checks the block, holds, then acks.
    task automatic collect();
        exp_t e;
        chk("sb_pending", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 36; k++)
                chk($sformatf("blk_w%0d", k), 64'(out[1151-32*k -: 32]), 64'(e.blk[1151-32*k -: 32]));
            chk("out_last", 64'(out_last), 64'(e.last));
        end
        chk("full_at_rdy", 64'(buffer_full), 1);
        last_blk = out;
        repeat (2) @(negedge clk);
        chk("rdy_hold", 64'(out_ready), 1);
        chk("full_hold", 64'(buffer_full), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("rdy_after_ack", 64'(out_ready), 0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] bn,
                             input logic [1:0] md);
        int guard = 0;
        in4 = w; is_last = last; byte_num = bn; mode = md; in_ready = 1'b1;
        while (buffer_full && guard < 400) begin
            if (out_ready) collect();
            else @(negedge clk);
            guard++;
        end
        chk("accept_bound", 64'(guard < 400), 1);
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg, input logic [1:0] m0, input logic [1:0] m1,
                            input bit drain, output int lat);
        int          n, nw, nv;
        logic [31:0] wd;
        n  = msg.size();
        nw = n / 4;
        lat = 0;
        model_push(msg, rbytes(m0));
        for (int w = 0; w <= nw; w++) begin
            wd = $urandom;
            nv = (w < nw) ? 4 : n % 4;
            for (int k = 0; k < nv; k++) wd[31-8*k -: 8] = msg[4*w+k];
            send_word(wd, w == nw, (w == nw) ? 2'(n % 4) : 2'd0, (w == 0) ? m0 : m1);
        end
        if (drain) begin
            lat = 1;
            while (!out_ready && lat < 400) begin
                @(negedge clk);
                lat++;
            end
            chk("final_rdy", 64'(out_ready), 1);
            if (out_ready) collect();
        end
    endtask

    task automatic run8();
        bq_t  m;
        exp_t e;
        int   g = 0;
        for (int i = 0; i < 20; i++) m.push_back(8'(8'hA0 + i));
        model_push(m, 136);
        for (int w = 0; w < 3; w++) begin
            in8 = {$urandom, $urandom};
            for (int k = 0; k < ((w < 2) ? 8 : 4); k++) in8[63-8*k -: 8] = m[8*w+k];
            is_last8  = (w == 2);
            byte_num8 = (w == 2) ? 3'd4 : 3'd0;
            mode8     = (w == 0) ? 2'd1 : 2'd3;
            in_ready8 = 1'b1;
            @(negedge clk);
        end
        in_ready8 = 1'b0;
        while (!out_ready8 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("d8_rdy", 64'(out_ready8), 1);
        chk("d8_last", 64'(out_last8), 1);
        chk("sb_pending8", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 18; k++)
                chk($sformatf("d8_w%0d", k), out8[1151-64*k -: 64], e.blk[1151-64*k -: 64]);
        end
        chk("d8_w2_const", out8[1151-128 -: 64], {32'hB0B1B2B3, PB, 24'h0});
        chk("d8_w16_const", out8[1151-1024 -: 64], 64'h80);
        ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
        chk("d8_rdy_ack", 64'(out_ready8), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bq_t m;
        int  lat;
        reset = 1'b1; in4 = '0; in_ready = 0; is_last = 0; byte_num = '0; mode = '0; ack = 0;
        in8 = '0; in_ready8 = 0; is_last8 = 0; byte_num8 = '0; mode8 = '0; ack8 = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_zero", 64'(out == '0), 1);
        chk("rst_rdy", 64'(out_ready), 0);
        chk("rst_last", 64'(out_last), 0);
        chk("rst_full", 64'(buffer_full), 0);
        reset = 1'b0;

        // Stray ack with nothing ready.
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("stray_ack_full", 64'(buffer_full), 0);
        chk("stray_ack_rdy", 64'(out_ready), 0);

        // Short message, PAD path.
        send_msg(str2q("Hello, world"), 2'd3, 2'd3, 1'b1, lat);
        chk("short_lat", 64'(lat), 15);
        chk("short_w0", 64'(last_blk[1151 -: 32]), 64'h48656c6c);
        chk("short_w3", 64'(last_blk[1151-96 -: 32]), {32'h0, PB, 24'h0});
        chk("short_w17", 64'(last_blk[1151-544 -: 32]), 64'h80);

        // Pad byte lands in the final byte of the block.
        m.delete();
        for (int i = 0; i < 68; i++) m.push_back(8'(i * 5 + 1));
        m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        send_msg(m, 2'd3, 2'd3, 1'b1, lat);
        chk("abc_lat", 64'(lat), 1);
        chk("abc_w17", 64'(last_blk[1151-544 -: 32]), {32'h0, 24'h616263, PB | 8'h80});

        // Two blocks: the second holds only padding.
        m.delete();
        for (int i = 0; i < 72; i++) m.push_back(8'(i * 7 + 3));
        send_msg(m, 2'd3, 2'd3, 1'b1, lat);
        chk("multi_w0", 64'(last_blk[1151 -: 32]), {32'h0, PB, 24'h0});
        chk("multi_w17", 64'(last_blk[1151-544 -: 32]), 64'h80);

        // Mode latched on the first word only.
        send_msg(str2q("0123456789"), 2'd0, 2'd3, 1'b1, lat);
        chk("latch_w17", 64'(last_blk[1151-544 -: 32]), 64'h0);
        chk("latch_w35", 64'(last_blk[1151-1120 -: 32]), 64'h80);

        run8();

        // Reset while padding discards the message.
        send_word(32'h4869ABCD, 1'b1, 2'd2, 2'd3);
        @(negedge clk);
        chk("pad_full", 64'(buffer_full), 1);
        chk("pad_rdy", 64'(out_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("padrst_out", 64'(out == '0), 1);
        chk("padrst_rdy", 64'(out_ready), 0);
        chk("padrst_last", 64'(out_last), 0);
        chk("padrst_full", 64'(buffer_full), 0);

        // Back to back: the next message's first word is held across the ack.
        send_msg(str2q("back"), 2'd3, 2'd3, 1'b0, lat);
        send_msg(str2q("to back!!"), 2'd2, 2'd0, 1'b1, lat);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_padder_p.md
KECCAK_PADDER_P -- requirements
Module: keccak_padder_p

Interface
REQ-001 SHALL have parameter IN_BYTES, default 4 (legal 4 or 8): bytes per input word.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in  in  8*IN_BYTES  message word; first byte is the most significant.
- in_ready  in  1  word valid.
- is_last  in  1  final word of message.
- byte_num  in  clog2(IN_BYTES)  valid bytes in the last word (0..IN_BYTES-1).
- mode  in  2  rate select.
- ack  in  1  consumer has taken the block.
- buffer_full  out  1  word not accepted this cycle.
- out  out  1152  rate block, word 0 in bits [1151 -: 8*IN_BYTES], left-aligned.
- out_ready  out  1  block valid.
- out_last  out  1  block is the message's final block.

Function
REQ-003 SHALL map mode to rate: 0->1152, 1->1088, 2->832, 3->576 bits. Words per block WPB = rate/(8*IN_BYTES). Bits of out below the rate SHALL be zero.
REQ-004 SHALL latch mode when the first word of a message is accepted; later mode changes within that message SHALL be ignored.
REQ-005 SHALL accept a word when in_ready=1 and buffer_full=0, writing it at word index cnt, then incrementing cnt.
REQ-006 SHALL implement states FILL, PAD, FULL, DONE:
- FILL -> FULL when word WPB-1 is accepted with is_last=0.
- FILL -> PAD when is_last is accepted and cnt<WPB-1.
- FILL -> DONE when is_last is accepted at index WPB-1.
- PAD -> DONE after writing index WPB-1.
- FULL -> FILL on ack, with cnt=0 and the block cleared.
- DONE -> FILL on ack, ready for a new message.
REQ-007 The last word SHALL be formed as: the byte_num valid bytes, then pad byte P, then zero bytes. Bytes of in past byte_num SHALL be ignored.
REQ-008 In PAD, SHALL write one zero word per cycle, with no input accepted.
REQ-009 The final byte of the block SHALL be ORed with 0x80. If P falls in that byte, it SHALL hold P|0x80.
REQ-010 A message whose length is a multiple of the word size SHALL end with a separate is_last word carrying byte_num=0.
REQ-011 buffer_full SHALL be 1 in PAD, FULL and DONE, and 0 in FILL.
REQ-012 out_ready SHALL be 1 in FULL and DONE, registered, from the cycle after the final word is written. out_last SHALL be 1 only in DONE.
REQ-013 ack while out_ready=0 SHALL be ignored. in_ready in the same cycle as ack SHALL not be accepted; the word is accepted from the next cycle.

Reset
REQ-014 reset SHALL clear the block, cnt and latched mode, and force state FILL, buffer_full=0, out_ready=0, out_last=0.
REQ-015 reset mid-message or mid-PAD SHALL discard all partial data. reset SHALL have priority over in_ready and ack.

Configuration
REQ-016 With KECCAK_SHA3_PAD_EN defined, P SHALL be 0x06 (FIPS-202 SHA-3 padding).
REQ-017 Without KECCAK_SHA3_PAD_EN, P SHALL be 0x01 (original Keccak padding).

Structure
REQ-018 Package keccak_pkg SHALL hold the mode encoding, the rate and WPB constants per mode and IN_BYTES, the pad constants, and the state enum.
REQ-019 SHALL instantiate combinational sub-module keccak_pad_word, which takes (in, byte_num, is_last) and produces the padded word.

Verification
REQ-020 SHALL cover the following scenarios, with IN_BYTES=4 and KECCAK_SHA3_PAD_EN defined unless stated:
- Short message: mode=3; "Hell","o, w","orld", then in=0 with is_last and byte_num=0 -> block words 0..2 = message, word3=0x06000000, words 4..16=0, word17=0x00000080. out_ready rises 15 cycles after the is_last accept; out_last=1.
- Pad byte in the final byte: mode=3; 17 full words, then "abc?" with byte_num=3 and is_last -> word17=0x61626386, with no PAD cycles.
- Multi-block message: mode=3; 18 words with is_last=0 -> out_ready=1, out_last=0, buffer_full=1, and in_ready ignored. Then ack, then is_last with byte_num=0 -> second block word0=0x06000000, word17=0x00000080, out_last=1.
- Mode latch and rate: mode=0 at the first word, mode=3 afterwards -> block of 36 words, pad ends at word35. Repeat with IN_BYTES=8 and mode=1 -> 17 words.
- Reset and back-to-back messages: reset asserted in PAD -> all outputs 0 next cycle. Then ack in DONE with in_ready=1 in the same cycle -> that word is not taken, and the next message starts cleanly.
- Keccak padding: without KECCAK_SHA3_PAD_EN, the short-message case -> word3=0x01000000.
